// File: rtl/sdr_cmd_monitor.sv
// Passive SDRAM command-bus monitor. It decodes commands, tracks open/closed state per bank,
// checks tRCD/tRP/tRAS and bank protocol rules, and keeps event counters and sticky error flags.
module sdr_cmd_monitor #(
  parameter int NUM_BANKS = 4,
  parameter int BA_W      = 2,
  parameter int ROW_W     = 13,
  parameter int CNT_W     = 16,
  parameter int T_RCD     = 3,
  parameter int T_RP      = 3,
  parameter int T_RAS     = 6
) (
  input  logic                 sdram_clk,
  input  logic                 sdram_rst,
  input  logic                 sdr_cke,
  input  logic                 sdr_cs_n,
  input  logic                 sdr_ras_n,
  input  logic                 sdr_cas_n,
  input  logic                 sdr_we_n,
  input  logic [BA_W-1:0]      sdr_ba,
  input  logic [ROW_W-1:0]     sdr_addr,
  input  logic                 clr_cnt,
  input  logic                 clr_err,
  output logic                 cmd_valid,
  output logic [3:0]           cmd_code,
  output logic [NUM_BANKS-1:0] bank_open,
  output logic [CNT_W-1:0]     act_cnt,
  output logic [CNT_W-1:0]     rd_cnt,
  output logic [CNT_W-1:0]     wr_cnt,
  output logic [CNT_W-1:0]     pre_cnt,
  output logic [CNT_W-1:0]     ref_cnt,
  output logic                 err_rcd,
  output logic                 err_rp,
  output logic                 err_ras,
  output logic                 err_closed,
  output logic                 err_act_open,
  output logic                 err_ref_open,
  output logic [BA_W-1:0]      err_bank
);

  typedef enum logic [3:0] {
    C_NOP  = 4'd0,
    C_ACT  = 4'd1,
    C_RD   = 4'd2,
    C_WR   = 4'd3,
    C_PRE  = 4'd4,
    C_PALL = 4'd5,
    C_REF  = 4'd6,
    C_MRS  = 4'd7,
    C_BST  = 4'd8
  } cmd_e;

  localparam int T_MAX_A = (T_RCD > T_RAS) ? T_RCD : T_RAS;
  localparam int T_MAX   = (T_MAX_A > T_RP) ? T_MAX_A : T_RP;
  localparam int SW      = $clog2(T_MAX + 2);

  localparam logic [SW-1:0] RCD_L = SW'(T_RCD);
  localparam logic [SW-1:0] RP_L  = SW'(T_RP);
  localparam logic [SW-1:0] RAS_L = SW'(T_RAS);
  localparam logic [SW-1:0] S_MAX = '1;

  cmd_e            dec;
  cmd_e            cmd_q;
  logic [BA_W-1:0] ba_q;
  logic            clr_cnt_q;
  logic            clr_err_q;

  logic [SW-1:0] since_act [NUM_BANKS];
  logic [SW-1:0] since_pre [NUM_BANKS];

  // X/Z on any control pin matches no case item and therefore falls through to NOP.
  always_comb begin
    dec = C_NOP;
    case ({sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n})
      5'b10011: dec = C_ACT;
      5'b10101: dec = C_RD;
      5'b10100: dec = C_WR;
      5'b10010: dec = (sdr_addr[10] == 1'b1) ? C_PALL : C_PRE;
      5'b10001: dec = C_REF;
      5'b10000: dec = C_MRS;
      5'b10110: dec = C_BST;
      default:  dec = C_NOP;
    endcase
  end

  // Input stage; clears travel with the command so they line up with it.
  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      cmd_q     <= C_NOP;
      ba_q      <= '0;
      clr_cnt_q <= 1'b0;
      clr_err_q <= 1'b0;
    end else begin
      cmd_q     <= dec;
      ba_q      <= sdr_ba;
      clr_cnt_q <= clr_cnt;
      clr_err_q <= clr_err;
    end
  end

  logic [NUM_BANKS-1:0] act_hit, rw_hit, pre_hit;
  logic [NUM_BANKS-1:0] v_act_open, v_rp, v_closed, v_rcd, v_ras;
  logic [NUM_BANKS-1:0] open_nxt;
  logic                 ref_hit, v_ref_open, new_err, err_any;
  logic [BA_W-1:0]      low_open, low_ras, new_bank;

  always_comb begin
    act_hit    = '0;
    rw_hit     = '0;
    pre_hit    = '0;
    v_act_open = '0;
    v_rp       = '0;
    v_closed   = '0;
    v_rcd      = '0;
    v_ras      = '0;
    open_nxt   = bank_open;
    low_open   = '0;
    low_ras    = '0;
    ref_hit    = (cmd_q == C_REF) || (cmd_q == C_MRS);
    for (int b = 0; b < NUM_BANKS; b++) begin
      act_hit[b]    = (cmd_q == C_ACT) && (ba_q == BA_W'(b));
      rw_hit[b]     = ((cmd_q == C_RD) || (cmd_q == C_WR)) && (ba_q == BA_W'(b));
      pre_hit[b]    = ((cmd_q == C_PRE) && (ba_q == BA_W'(b))) || (cmd_q == C_PALL);
      v_act_open[b] = act_hit[b] && bank_open[b];
      v_rp[b]       = act_hit[b] && (since_pre[b] < RP_L);
      v_closed[b]   = rw_hit[b] && !bank_open[b];
      v_rcd[b]      = rw_hit[b] && bank_open[b] && (since_act[b] < RCD_L);
      v_ras[b]      = pre_hit[b] && bank_open[b] && (since_act[b] < RAS_L);
      if (pre_hit[b]) open_nxt[b] = 1'b0;
      if (act_hit[b]) open_nxt[b] = 1'b1;
    end
    // Scan downwards so the lowest index is the one left standing.
    for (int b = NUM_BANKS - 1; b >= 0; b--) begin
      if (bank_open[b]) low_open = BA_W'(b);
      if (v_ras[b])     low_ras  = BA_W'(b);
    end
    v_ref_open = ref_hit && (|bank_open);
    new_err    = (|v_act_open) || (|v_rp) || (|v_closed) || (|v_rcd) || (|v_ras) || v_ref_open;
    if (ref_hit)              new_bank = low_open;
    else if (cmd_q == C_PALL) new_bank = low_ras;
    else                      new_bank = ba_q;
    err_any = err_rcd || err_rp || err_ras || err_closed || err_act_open || err_ref_open;
  end

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] cnt,
                                            input logic inc, input logic clr);
    logic [CNT_W-1:0] base;
    base = clr ? '0 : cnt;
    if (inc && (base != '1)) return base + CNT_W'(1);
    return base;
  endfunction

  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        since_act[b] <= S_MAX;
        since_pre[b] <= S_MAX;
      end
      bank_open    <= '0;
      cmd_valid    <= 1'b0;
      cmd_code     <= 4'd0;
      act_cnt      <= '0;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      pre_cnt      <= '0;
      ref_cnt      <= '0;
      err_rcd      <= 1'b0;
      err_rp       <= 1'b0;
      err_ras      <= 1'b0;
      err_closed   <= 1'b0;
      err_act_open <= 1'b0;
      err_ref_open <= 1'b0;
      err_bank     <= '0;
    end else begin
      // Set to 1 on the command so the value seen k edges later equals the distance k.
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (act_hit[b])                since_act[b] <= SW'(1);
        else if (since_act[b] != S_MAX) since_act[b] <= since_act[b] + SW'(1);
        if (pre_hit[b])                since_pre[b] <= SW'(1);
        else if (since_pre[b] != S_MAX) since_pre[b] <= since_pre[b] + SW'(1);
      end
      bank_open <= open_nxt;
      cmd_valid <= (cmd_q != C_NOP);
      cmd_code  <= cmd_q;

      act_cnt <= bump(act_cnt, cmd_q == C_ACT, clr_cnt_q);
      rd_cnt  <= bump(rd_cnt,  cmd_q == C_RD,  clr_cnt_q);
      wr_cnt  <= bump(wr_cnt,  cmd_q == C_WR,  clr_cnt_q);
      pre_cnt <= bump(pre_cnt, (cmd_q == C_PRE) || (cmd_q == C_PALL), clr_cnt_q);
      ref_cnt <= bump(ref_cnt, cmd_q == C_REF, clr_cnt_q);

      err_rcd      <= (err_rcd      && !clr_err_q) || (|v_rcd);
      err_rp       <= (err_rp       && !clr_err_q) || (|v_rp);
      err_ras      <= (err_ras      && !clr_err_q) || (|v_ras);
      err_closed   <= (err_closed   && !clr_err_q) || (|v_closed);
      err_act_open <= (err_act_open && !clr_err_q) || (|v_act_open);
      err_ref_open <= (err_ref_open && !clr_err_q) || v_ref_open;

      if (new_err && (clr_err_q || !err_any)) err_bank <= new_bank;
      else if (clr_err_q)                     err_bank <= '0;
    end
  end

endmodule

// File: tb/tb_sdr_cmd_monitor.sv
// Directed bench for sdr_cmd_monitor: default instance plus a CNT_W=2 instance for saturation.
module tb_sdr_cmd_monitor;

  localparam logic [3:0] NOP = 0, ACT = 1, RD = 2, WR = 3, PRE = 4, PALL = 5, REF = 6, MRS = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cke = 1'b1, cs_n = 1'b0, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [1:0]  ba = '0;
  logic [12:0] addr = '0;
  logic        clr_cnt = 1'b0, clr_err = 1'b0;

  logic        cmd_valid;
  logic [3:0]  cmd_code;
  logic [3:0]  bank_open;
  logic [15:0] act_cnt, rd_cnt, wr_cnt, pre_cnt, ref_cnt;
  logic        err_rcd, err_rp, err_ras, err_closed, err_act_open, err_ref_open;
  logic [1:0]  err_bank;

  logic        d2_valid;
  logic [3:0]  d2_code;
  logic [3:0]  d2_open;
  logic [1:0]  d2_act, d2_rd, d2_wr, d2_pre, d2_ref;
  logic        d2_rcd, d2_rp, d2_ras, d2_closed, d2_act_open, d2_ref_open;
  logic [1:0]  d2_bank;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sdr_cmd_monitor dut (
    .sdram_clk(clk), .sdram_rst(rst), .sdr_cke(cke), .sdr_cs_n(cs_n), .sdr_ras_n(ras_n),
    .sdr_cas_n(cas_n), .sdr_we_n(we_n), .sdr_ba(ba), .sdr_addr(addr),
    .clr_cnt(clr_cnt), .clr_err(clr_err), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .bank_open(bank_open), .act_cnt(act_cnt), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
    .pre_cnt(pre_cnt), .ref_cnt(ref_cnt), .err_rcd(err_rcd), .err_rp(err_rp),
    .err_ras(err_ras), .err_closed(err_closed), .err_act_open(err_act_open),
    .err_ref_open(err_ref_open), .err_bank(err_bank)
  );

  sdr_cmd_monitor #(.CNT_W(2)) dut2 (
    .sdram_clk(clk), .sdram_rst(rst), .sdr_cke(cke), .sdr_cs_n(cs_n), .sdr_ras_n(ras_n),
    .sdr_cas_n(cas_n), .sdr_we_n(we_n), .sdr_ba(ba), .sdr_addr(addr),
    .clr_cnt(clr_cnt), .clr_err(clr_err), .cmd_valid(d2_valid), .cmd_code(d2_code),
    .bank_open(d2_open), .act_cnt(d2_act), .rd_cnt(d2_rd), .wr_cnt(d2_wr),
    .pre_cnt(d2_pre), .ref_cnt(d2_ref), .err_rcd(d2_rcd), .err_rp(d2_rp),
    .err_ras(d2_ras), .err_closed(d2_closed), .err_act_open(d2_act_open),
    .err_ref_open(d2_ref_open), .err_bank(d2_bank)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one bus cycle, waits for the sampling edge, then returns the bus to NOP.
  task automatic drive(input logic [3:0] pins, input logic [1:0] b, input logic a10,
                       input logic ck);
    {cs_n, ras_n, cas_n, we_n} = pins;
    ba = b;
    addr = '0;
    addr[10] = a10;
    cke = ck;
    @(posedge clk);
    #1;
    {cs_n, ras_n, cas_n, we_n} = 4'b0111;
    cke = 1'b1;
    addr = '0;
    clr_cnt = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic issue(input logic [3:0] c, input logic [1:0] b);
    case (c)
      ACT:     drive(4'b0011, b, 1'b0, 1'b1);
      RD:      drive(4'b0101, b, 1'b0, 1'b1);
      WR:      drive(4'b0100, b, 1'b0, 1'b1);
      PRE:     drive(4'b0010, b, 1'b0, 1'b1);
      PALL:    drive(4'b0010, b, 1'b1, 1'b1);
      REF:     drive(4'b0001, b, 1'b0, 1'b1);
      MRS:     drive(4'b0000, b, 1'b0, 1'b1);
      default: drive(4'b0111, b, 1'b0, 1'b1);
    endcase
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) issue(NOP, 2'd0);
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    issue(NOP, 2'd0);
    nop(1);
  endtask

  initial begin
    nop(2);
    rst = 1'b0;
    chk("rst_valid", cmd_valid, 0);
    chk("rst_open", bank_open, 0);
    chk("rst_act_cnt", act_cnt, 0);
    chk("rst_errs", {err_rcd, err_rp, err_ras, err_closed, err_act_open, err_ref_open}, 0);

    // cke low and cs_n high both mask an ACT pattern
    drive(4'b0011, 2'd0, 1'b0, 1'b0);
    drive(4'b1011, 2'd0, 1'b0, 1'b1);
    chk("cke0_valid", cmd_valid, 0);
    nop(1);
    chk("csn1_open", bank_open, 0);
    chk("mask_act_cnt", act_cnt, 0);

    // legal ACT@0 RD@3 PRE@6 ACT@9 on bank 0
    issue(ACT, 0); nop(2);
    issue(RD, 0);  nop(1);
    chk("rd_code", cmd_code, RD);
    nop(1);
    issue(PRE, 0); nop(2);
    issue(ACT, 0); nop(1);
    chk("seq_valid", cmd_valid, 1);
    chk("seq_code", cmd_code, ACT);
    chk("seq_open", bank_open, 4'b0001);
    chk("seq_act_cnt", act_cnt, 2);
    chk("seq_rd_cnt", rd_cnt, 1);
    chk("seq_pre_cnt", pre_cnt, 1);
    chk("seq_errs", {err_rcd, err_rp, err_ras, err_closed, err_act_open, err_ref_open}, 0);
    nop(5);
    issue(PRE, 0); nop(8);

    // tRCD violation: ACT b1@0, WR b1@2
    issue(ACT, 1); nop(1);
    issue(WR, 1);  nop(1);
    chk("rcd_flag", err_rcd, 1);
    chk("rcd_bank", err_bank, 1);
    chk("rcd_wr_cnt", wr_cnt, 1);
    chk("rcd_others", {err_rp, err_ras, err_closed, err_act_open, err_ref_open}, 0);
    nop(6);
    issue(PRE, 1); nop(2);
    clear_errors();
    chk("clr_rcd", err_rcd, 0);
    chk("clr_bank", err_bank, 0);
    nop(8);

    // tRAS then tRP violation on bank 2
    issue(ACT, 2); nop(3);
    issue(PRE, 2); nop(1);
    chk("ras_flag", err_ras, 1);
    chk("ras_open", bank_open, 0);
    issue(ACT, 2); nop(1);
    chk("rp_flag", err_rp, 1);
    chk("rp_bank", err_bank, 2);
    chk("rp_open", bank_open, 4'b0100);
    nop(6);
    issue(PRE, 2); nop(2);
    clear_errors();
    nop(8);

    // closed-bank read, double ACT, REF with an open bank
    issue(RD, 3); nop(1);
    chk("closed_flag", err_closed, 1);
    chk("closed_bank", err_bank, 3);
    issue(ACT, 0);
    issue(ACT, 0); nop(1);
    chk("act_open_flag", err_act_open, 1);
    chk("act_open_bank", err_bank, 3);
    chk("act_open_no_rp", err_rp, 0);
    issue(REF, 0); nop(1);
    chk("ref_open_flag", err_ref_open, 1);
    nop(6);
    issue(PRE, 0); nop(2);
    clear_errors();
    clr_cnt = 1'b1;
    issue(NOP, 0); nop(1);
    chk("clr_cnt_act", act_cnt, 0);
    chk("clr_cnt_pre", pre_cnt, 0);

    // ACT b0/b2, PALL@10, REF@13
    issue(ACT, 0);
    issue(ACT, 2); nop(1);
    chk("pall_pre_open", bank_open, 4'b0101);
    nop(7);
    issue(PALL, 0); nop(1);
    chk("pall_code", cmd_code, PALL);
    chk("pall_open", bank_open, 0);
    chk("pall_pre_cnt", pre_cnt, 1);
    nop(1);
    issue(REF, 0); nop(1);
    chk("pall_ref_cnt", ref_cnt, 1);
    chk("pall_act_cnt", act_cnt, 2);
    chk("pall_errs", {err_rcd, err_rp, err_ras, err_closed, err_act_open, err_ref_open}, 0);

    // early PALL over banks 3 and 1: lowest violating bank recorded
    issue(ACT, 3);
    issue(ACT, 1);
    issue(PALL, 0); nop(1);
    chk("pall_ras_flag", err_ras, 1);
    chk("pall_ras_bank", err_bank, 1);
    chk("pall_ras_open", bank_open, 0);
    nop(8);
    clear_errors();
    clr_cnt = 1'b1;
    issue(NOP, 0); nop(1);

    // five ACT/PRE pairs: CNT_W=2 instance saturates at 3
    for (int i = 0; i < 5; i++) begin
      issue(ACT, 0); nop(5);
      issue(PRE, 0); nop(2);
    end
    chk("sat_d2_act", d2_act, 3);
    chk("sat_d2_pre", d2_pre, 3);
    chk("sat_d1_act", act_cnt, 5);
    chk("sat_errs", {err_rcd, err_rp, err_ras, err_closed, err_act_open, err_ref_open}, 0);
    clr_cnt = 1'b1;
    issue(ACT, 0); nop(1);
    chk("clr_act_d1", act_cnt, 1);
    chk("clr_act_d2", d2_act, 1);
    chk("clr_act_pre", pre_cnt, 0);

    // clr_err coinciding with a new error: the new error wins
    issue(ACT, 0); nop(1);
    chk("pre_clr_act_open", err_act_open, 1);
    clr_err = 1'b1;
    issue(RD, 1); nop(1);
    chk("clr_new_closed", err_closed, 1);
    chk("clr_old_gone", err_act_open, 0);
    chk("clr_new_bank", err_bank, 1);

    // reset mid-sequence discards open bank 0
    rst = 1'b1;
    issue(NOP, 0);
    rst = 1'b0;
    chk("mid_rst_open", bank_open, 0);
    chk("mid_rst_err", err_closed, 0);
    chk("mid_rst_cnt", act_cnt, 0);
    issue(ACT, 0); nop(1);
    chk("post_rst_act", {err_act_open, err_rp}, 0);
    chk("post_rst_open", bank_open, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
